// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the uart transmit handshake; reports fill level and a sticky overflow flag.
// Optional feature: define UART_TX_CRLF_EN to append 0x0A after every popped 0x0D.
module uart_tx_queue #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic                  transmit,
    output logic [7:0]            tx_byte,
    input  logic                  is_transmitting
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2:0]   cnt_t;
    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

`ifdef UART_TX_CRLF_EN
    localparam logic [7:0] CR_BYTE = 8'h0D;
    localparam logic [7:0] LF_BYTE = 8'h0A;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
`ifdef UART_TX_CRLF_EN
        ,
        LF    = 2'd3
`endif
    } state_t;

    logic [7:0] mem [DEPTH];
    ptr_t       wr_ptr;
    ptr_t       rd_ptr;
    state_t     state;

    logic       push_c;
    logic       drop_c;
    logic       pop_c;
    cnt_t       count_nxt;
    logic [7:0] head_c;

    // An empty FIFO lets a same-cycle push fall straight through to the UART.
    always_comb begin
        push_c    = wr_en && !full;
        drop_c    = wr_en && full;
        pop_c     = (state == IDLE) && (!empty || push_c) && !is_transmitting;
        head_c    = empty ? wr_data : mem[rd_ptr];
        count_nxt = count;
        if (push_c && !pop_c) begin
            count_nxt = count + cnt_t'(1);
        end else if (pop_c && !push_c) begin
            count_nxt = count - cnt_t'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == cnt_t'(0));
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Transmit sequencer: one start pulse per byte, then wait out the UART frame.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            transmit <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            transmit <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        tx_byte  <= head_c;
                        transmit <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (is_transmitting) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!is_transmitting) begin
`ifdef UART_TX_CRLF_EN
                        state <= (tx_byte == CR_BYTE) ? LF : IDLE;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef UART_TX_CRLF_EN
                LF: begin
                    if (!is_transmitting) begin
                        tx_byte  <= LF_BYTE;
                        transmit <= 1'b1;
                        state    <= START;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with a simple UART busy model.
module tb_uart_tx_queue;

    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned DEPTH      = 16;
    localparam int          FRAME      = 10;

    logic                CLK = 1'b0;
    logic                rst = 1'b1;
    logic                wr_en = 1'b0;
    logic [7:0]          wr_data = 8'h00;
    logic                clr_overflow = 1'b0;
    logic                hold = 1'b0;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                transmit;
    logic [7:0]          tx_byte;
    logic                is_transmitting;

    int         busy_cnt = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         n_pulses = 0;
    int         pulses_before = 0;
    logic [7:0] exp_q [$];
    logic       prev_trans = 1'b0;
    logic [7:0] prev_tx = 8'h00;

    assign is_transmitting = hold || (busy_cnt != 0);

    always #5 CLK = ~CLK;

    uart_tx_queue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .CLK             (CLK),
        .rst             (rst),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .full            (full),
        .empty           (empty),
        .count           (count),
        .overflow        (overflow),
        .clr_overflow    (clr_overflow),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (is_transmitting)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // UART model and output monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (busy_cnt > 0) busy_cnt--;
        if (rst) begin
            prev_trans = 1'b0;
            prev_tx    = tx_byte;
        end else begin
            if (transmit) begin
                n_pulses++;
                check("pulse_width", 32'(prev_trans), 32'd0);
                if (exp_q.size() == 0) check("tx_extra", 32'(exp_q.size()), 32'd1);
                else check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
                busy_cnt = FRAME;
            end else begin
                check("tx_stable", 32'(tx_byte), 32'(prev_tx));
            end
            prev_trans = transmit;
            prev_tx    = tx_byte;
        end
    end

    task automatic push(input logic [7:0] d, input bit accept);
        @(negedge CLK);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) begin
            exp_q.push_back(d);
`ifdef UART_TX_CRLF_EN
            if (d == 8'h0D) exp_q.push_back(8'h0A);
`endif
        end
    endtask

    task automatic end_push();
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && busy_cnt == 0 && empty && !transmit) done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_transmit", 32'(transmit), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'h00);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Basic send with one-cycle latency
        push(8'h41, 1'b1);
        end_push();
        check("lat_transmit", 32'(transmit), 32'd1);
        check("lat_byte", 32'(tx_byte), 32'h41);
        drain();
        check("basic_empty", 32'(empty), 32'd1);

        // Burst while the line is held busy, then overflow
        hold = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) push(8'(i), 1'b1);
        end_push();
        check("burst_full", 32'(full), 32'd1);
        check("burst_count", 32'(count), 32'd16);
        check("burst_nonempty", 32'(empty), 32'd0);
        push(8'hAA, 1'b0);
        end_push();
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        hold = 1'b0;
        drain();
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("burst_drained", 32'(count), 32'd0);
        @(negedge CLK);
        clr_overflow = 1'b1;
        @(negedge CLK);
        clr_overflow = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);

        // Simultaneous push and pop at count 5
        hold = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i), 1'b1);
        end_push();
        check("pp_count_pre", 32'(count), 32'd5);
        push(8'h60, 1'b1);
        hold = 1'b0;
        end_push();
        check("pp_count", 32'(count), 32'd5);
        drain();

        // Push into a full FIFO coinciding with a pop
        hold = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) push(8'h80 + 8'(i), 1'b1);
        end_push();
        check("fp_full", 32'(full), 32'd1);
        push(8'hEE, 1'b0);
        hold = 1'b0;
        end_push();
        check("fp_count", 32'(count), 32'd15);
        check("fp_overflow", 32'(overflow), 32'd1);
        check("fp_not_full", 32'(full), 32'd0);
        drain();
        @(negedge CLK);
        clr_overflow = 1'b1;
        @(negedge CLK);
        clr_overflow = 1'b0;

        // Asynchronous reset mid-burst
        hold = 1'b1;
        for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i), 1'b1);
        end_push();
        check("mr_count_pre", 32'(count), 32'd8);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mr_count", 32'(count), 32'd0);
        check("mr_empty", 32'(empty), 32'd1);
        check("mr_transmit", 32'(transmit), 32'd0);
        check("mr_full", 32'(full), 32'd0);
        repeat (2) @(negedge CLK);
        rst = 1'b0;
        hold = 1'b0;
        pulses_before = n_pulses;
        repeat (40) @(negedge CLK);
        check("mr_no_pulse", 32'(n_pulses), 32'(pulses_before));
        check("mr_count_post", 32'(count), 32'd0);

        // CR handling
        pulses_before = n_pulses;
        push(8'h0D, 1'b1);
        push(8'h42, 1'b1);
        end_push();
        drain();
`ifdef UART_TX_CRLF_EN
        check("crlf_pulses", 32'(n_pulses - pulses_before), 32'd3);
`else
        check("crlf_pulses", 32'(n_pulses - pulses_before), 32'd2);
`endif
        check("final_empty", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
